// File: rtl/store_buffer_if.sv
// Bundles the core store/load ports and the memory drain bus of store_buffer.
// slave = the buffer itself, master = the core/memory environment driving it.
interface store_buffer_if #(
    parameter int AW    = 12,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_err;

    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          ld_conflict;
    logic [31:0]   ld_data;

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;

    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, ld_addr, mem_ack,
        output st_ready, st_err, ld_hit, ld_conflict, ld_data,
               mem_req, mem_addr, mem_wdata, mem_be, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, ld_addr, mem_ack,
        input  st_ready, st_err, ld_hit, ld_conflict, ld_data,
               mem_req, mem_addr, mem_wdata, mem_be, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// In-order posted-write store buffer with load forwarding and a req/ack drain port.
// Optional tail merging of same-word stores is enabled by defining STORE_MERGE_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic         clk,
    input  logic         rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = AW - 2;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic [WW-1:0] addr_q [DEPTH];
    logic [WW-1:0] addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [3:0]    be_d   [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_err_q, st_err_d;

    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic          st_bad;
    logic          can_merge, full, st_fire, push, st_merge, pop;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        st_wdata = sb.st_data;
        st_be    = 4'b1111;
        st_bad   = 1'b0;
        case (size_e'(sb.st_size))
            SZ_WORD: st_bad = (sb.st_addr[1:0] != 2'b00);
            SZ_HALF: begin
                st_wdata = {2{sb.st_data[15:0]}};
                st_be    = sb.st_addr[1] ? 4'b1100 : 4'b0011;
                st_bad   = sb.st_addr[0];
            end
            SZ_BYTE: begin
                st_wdata = {4{sb.st_data[7:0]}};
                st_be    = 4'b0001 << sb.st_addr[1:0];
            end
            default: st_bad = 1'b1;
        endcase
    end

`ifdef STORE_MERGE_EN
    logic [PW-1:0] tail_idx;
    assign tail_idx  = wr_ptr_q - PW'(1);
    // The head may be acked this very cycle, so only a tail distinct from it can absorb a store.
    assign can_merge = (count_q >= CW'(2)) && (addr_q[tail_idx] == sb.st_addr[AW-1:2]);
`else
    assign can_merge = 1'b0;
`endif

    assign full     = (count_q == CW'(DEPTH));
    assign st_fire  = sb.st_valid && sb.st_ready;
    assign push     = st_fire && !st_bad && !can_merge;
    assign st_merge = st_fire && !st_bad && can_merge;
    assign pop      = (count_q != '0) && sb.mem_ack;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        st_err_d = st_fire && st_bad;
        if (push) begin
            addr_d[wr_ptr_q] = sb.st_addr[AW-1:2];
            data_d[wr_ptr_q] = st_wdata;
            be_d[wr_ptr_q]   = st_be;
        end
`ifdef STORE_MERGE_EN
        if (st_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) data_d[tail_idx][8*b +: 8] = st_wdata[8*b +: 8];
            end
            be_d[tail_idx] = be_q[tail_idx] | st_be;
        end
`else
        if (st_merge) st_err_d = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        be_q   <= be_d;
    end

    logic [PW-1:0] fwd_idx;
    logic          fwd_match;
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_be;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_idx   = '0;
        fwd_match = 1'b0;
        fwd_data  = '0;
        fwd_be    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == sb.ld_addr[AW-1:2])) begin
                fwd_match = 1'b1;
                fwd_data  = data_q[fwd_idx];
                fwd_be    = be_q[fwd_idx];
            end
        end
    end

    logic unused_ld_lsb;
    assign unused_ld_lsb = ^sb.ld_addr[1:0];

    assign sb.st_ready    = !full || can_merge;
    assign sb.st_err      = st_err_q;
    assign sb.ld_hit      = fwd_match && (fwd_be == 4'b1111);
    assign sb.ld_conflict = fwd_match && (fwd_be != 4'b1111);
    assign sb.ld_data     = fwd_data;
    assign sb.mem_req     = (count_q != '0);
    assign sb.mem_addr    = {addr_q[rd_ptr_q], 2'b00};
    assign sb.mem_wdata   = data_q[rd_ptr_q];
    assign sb.mem_be      = be_q[rd_ptr_q];
    assign sb.empty       = (count_q == '0);
    assign sb.count       = count_q;
endmodule
